// File: rtl/operand_fetch_stage.sv
// Operand-fetch / issue stage feeding arith_logic_unit.
// It holds the register file and a busy scoreboard, reads two operands with
// write-back bypass, and presents them through a one-entry output register.

// One architectural register together with its scoreboard bit.
// A write-back hit clears busy, and an accept targeting this register sets it.
// When both happen on the same edge the set wins, so the value updates but the
// register stays reserved for the newer producer.
module operand_fetch_reg_cell #(
  parameter int WORD_SIZE = 19
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wb_hit,
  input  logic [WORD_SIZE-1:0] wb_data,
  input  logic                 set_busy,
  output logic [WORD_SIZE-1:0] value,
  output logic                 hazard
);

  logic [WORD_SIZE-1:0] val_q, val_d;
  logic                 busy_q, busy_d;

  // next value / scoreboard state
  always_comb begin
    val_d  = val_q;
    busy_d = busy_q;
    if (wb_hit) begin
      val_d  = wb_data;
      busy_d = 1'b0;
    end
    if (set_busy) busy_d = 1'b1;
  end

  // register and busy flop, cleared immediately by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      val_q  <= val_d;
      busy_q <= busy_d;
    end
  end

  // a write-back arriving this cycle resolves the hazard; the value is bypassed
  assign value  = val_q;
  assign hazard = busy_q & ~wb_hit;

endmodule

module operand_fetch_stage #(
  parameter int WORD_SIZE   = 19,
  parameter int OPCODE_SIZE = 5,
  parameter int NUM_REGS    = 16,
  parameter int REG_ADDR_W  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   issue_valid,
  output logic                   issue_ready,
  input  logic [OPCODE_SIZE-1:0] issue_opcode,
  input  logic [REG_ADDR_W-1:0]  issue_rs1,
  input  logic [REG_ADDR_W-1:0]  issue_rs2,
  input  logic [REG_ADDR_W-1:0]  issue_rd,
  input  logic                   wb_en,
  input  logic [REG_ADDR_W-1:0]  wb_addr,
  input  logic [WORD_SIZE-1:0]   wb_data,
  output logic [WORD_SIZE-1:0]   reg_data_1,
  output logic [WORD_SIZE-1:0]   reg_data_2,
  output logic [OPCODE_SIZE-1:0] ALU_control,
  output logic [REG_ADDR_W-1:0]  alu_rd,
  output logic                   alu_valid,
  input  logic                   alu_ready
);

  typedef struct packed {
    logic [WORD_SIZE-1:0]   d1;
    logic [WORD_SIZE-1:0]   d2;
    logic [OPCODE_SIZE-1:0] op;
    logic [REG_ADDR_W-1:0]  rd;
  } alu_req_t;

  logic [NUM_REGS-1:0][WORD_SIZE-1:0] reg_val;
  logic [NUM_REGS-1:0]                reg_haz;
  logic [NUM_REGS-1:0]                wb_hit;
  logic [NUM_REGS-1:0]                set_busy;

  logic     accept;
  logic     haz;
  alu_req_t out_q, out_d;
  logic     alu_valid_q, alu_valid_d;
  logic [WORD_SIZE-1:0] op1, op2;

  // R0 is hardwired: always zero, never busy, never written
  assign reg_val[0]  = '0;
  assign reg_haz[0]  = 1'b0;
  assign wb_hit[0]   = 1'b0;
  assign set_busy[0] = 1'b0;

  genvar r;
  generate
    for (r = 1; r < NUM_REGS; r++) begin : g_reg
      assign wb_hit[r]   = wb_en  & (wb_addr  == REG_ADDR_W'(r));
      assign set_busy[r] = accept & (issue_rd == REG_ADDR_W'(r));
      operand_fetch_reg_cell #(.WORD_SIZE(WORD_SIZE)) u_cell (
        .clk      (clk),
        .rst      (rst),
        .wb_hit   (wb_hit[r]),
        .wb_data  (wb_data),
        .set_busy (set_busy[r]),
        .value    (reg_val[r]),
        .hazard   (reg_haz[r])
      );
    end
  endgenerate

  // RAW on either source, WAW on the destination
  assign haz         = reg_haz[issue_rs1] | reg_haz[issue_rs2] | reg_haz[issue_rd];
  assign issue_ready = ~rst & ~haz & (~alu_valid_q | alu_ready);
  assign accept      = issue_valid & issue_ready;

  // operand read with write-back bypass; R0 wins over a bypass to R0
  always_comb begin
    op1 = reg_val[issue_rs1];
    op2 = reg_val[issue_rs2];
    if (wb_hit[issue_rs1]) op1 = wb_data;
    if (wb_hit[issue_rs2]) op2 = wb_data;
    if (issue_rs1 == '0)   op1 = '0;
    if (issue_rs2 == '0)   op2 = '0;
  end

  // output stage: load on accept, drop valid when consumed, otherwise hold
  always_comb begin
    out_d       = out_q;
    alu_valid_d = alu_valid_q;
    if (accept) begin
      out_d.d1    = op1;
      out_d.d2    = op2;
      out_d.op    = issue_opcode;
      out_d.rd    = issue_rd;
      alu_valid_d = 1'b1;
    end else if (alu_ready) begin
      alu_valid_d = 1'b0;
    end
  end

  // output register; reset discards any held operation at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q       <= '0;
      alu_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      alu_valid_q <= alu_valid_d;
    end
  end

  assign reg_data_1  = out_q.d1;
  assign reg_data_2  = out_q.d2;
  assign ALU_control = out_q.op;
  assign alu_rd      = out_q.rd;
  assign alu_valid   = alu_valid_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: directed scenarios with literal expectations
// followed by random traffic, all checked against an array-based model.
module tb_operand_fetch_stage;

  localparam int WS = 19, OS = 5, NR = 16, AW = 4;
  localparam logic [OS-1:0] OP_ADD = 5'd1, OP_SUB = 5'd2, OP_AND = 5'd3, OP_DEC = 5'd7;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          issue_valid = 1'b0;
  logic          issue_ready;
  logic [OS-1:0] issue_opcode = '0;
  logic [AW-1:0] issue_rs1 = '0, issue_rs2 = '0, issue_rd = '0;
  logic          wb_en = 1'b0;
  logic [AW-1:0] wb_addr = '0;
  logic [WS-1:0] wb_data = '0;
  logic [WS-1:0] reg_data_1, reg_data_2;
  logic [OS-1:0] ALU_control;
  logic [AW-1:0] alu_rd;
  logic          alu_valid;
  logic          alu_ready = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  operand_fetch_stage #(.WORD_SIZE(WS), .OPCODE_SIZE(OS), .NUM_REGS(NR), .REG_ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_opcode(issue_opcode),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rd(issue_rd),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .reg_data_1(reg_data_1), .reg_data_2(reg_data_2), .ALU_control(ALU_control),
    .alu_rd(alu_rd), .alu_valid(alu_valid), .alu_ready(alu_ready)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [WS-1:0] m_regs [NR];
  bit            m_busy [NR];
  bit            m_valid = 1'b0;
  logic [WS-1:0] m_d1 = '0, m_d2 = '0;
  logic [OS-1:0] m_op = '0;
  logic [AW-1:0] m_rd = '0;

  initial for (int i = 0; i < NR; i++) begin m_regs[i] = '0; m_busy[i] = 1'b0; end

  function automatic bit m_haz(int r);
    return (r != 0) && m_busy[r] && !(wb_en && int'(wb_addr) == r);
  endfunction

  function automatic bit m_ready();
    return !rst && !(m_haz(int'(issue_rs1)) || m_haz(int'(issue_rs2)) || m_haz(int'(issue_rd)))
           && (!m_valid || alu_ready);
  endfunction

  function automatic logic [WS-1:0] m_read(int r);
    if (r == 0) return '0;
    if (wb_en && int'(wb_addr) == r) return wb_data;
    return m_regs[r];
  endfunction

  // model state update on every edge, reset clears everything at once
  always @(posedge clk or posedge rst) begin : model
    bit acc;
    if (rst) begin
      for (int i = 0; i < NR; i++) begin m_regs[i] <= '0; m_busy[i] <= 1'b0; end
      m_valid <= 1'b0; m_d1 <= '0; m_d2 <= '0; m_op <= '0; m_rd <= '0;
    end else begin
      acc = issue_valid && m_ready();
      if (acc) begin
        m_d1 <= m_read(int'(issue_rs1));
        m_d2 <= m_read(int'(issue_rs2));
        m_op <= issue_opcode;
        m_rd <= issue_rd;
        m_valid <= 1'b1;
      end else if (alu_ready) begin
        m_valid <= 1'b0;
      end
      if (wb_en && wb_addr != 0) begin
        m_regs[wb_addr] <= wb_data;
        m_busy[wb_addr] <= 1'b0;
      end
      if (acc && issue_rd != 0) m_busy[issue_rd] <= 1'b1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    chk("m_issue_ready", issue_ready, m_ready());
    chk("m_alu_valid",   alu_valid,   m_valid);
    chk("m_reg_data_1",  reg_data_1,  m_d1);
    chk("m_reg_data_2",  reg_data_2,  m_d2);
    chk("m_ALU_control", ALU_control, m_op);
    chk("m_alu_rd",      alu_rd,      m_rd);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input bit iv, input logic [OS-1:0] op, input int rs1, input int rs2, input int rd,
                       input bit we, input int wa, input int wd, input bit ar);
    issue_valid = iv; issue_opcode = op;
    issue_rs1 = AW'(rs1); issue_rs2 = AW'(rs2); issue_rd = AW'(rd);
    wb_en = we; wb_addr = AW'(wa); wb_data = WS'(wd); alu_ready = ar;
  endtask

  task automatic chk_out(input string nm, input bit v, input int d1, input int d2,
                         input logic [OS-1:0] op, input int rd);
    chk({nm, "_valid"}, alu_valid, v);
    chk({nm, "_d1"},    reg_data_1, d1);
    chk({nm, "_d2"},    reg_data_2, d2);
    chk({nm, "_op"},    ALU_control, op);
    chk({nm, "_rd"},    alu_rd, rd);
  endtask

  initial begin
    // reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", issue_ready, 0);
    chk_out("rst", 0, 0, 0, 5'd0, 0);
    #2 rst = 1'b0;
    @(posedge clk); #1;

    // load R1=10, R2=5
    drive(0, OP_ADD, 0, 0, 0, 1, 1, 10, 1); tick();
    drive(0, OP_ADD, 0, 0, 0, 1, 2, 5, 1);  tick();

    // ADD R3 = R1 + R2
    drive(1, OP_ADD, 1, 2, 3, 0, 0, 0, 1);
    #1 chk("add_ready", issue_ready, 1);
    tick();
    chk_out("add", 1, 10, 5, OP_ADD, 3);

    // RAW stall on R3 until write-back, then bypass
    drive(1, OP_SUB, 3, 2, 4, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      #1 chk("raw_stall", issue_ready, 0);
      tick();
    end
    drive(1, OP_SUB, 3, 2, 4, 1, 3, 15, 1);
    #1 chk("raw_release", issue_ready, 1);
    tick();
    chk_out("raw", 1, 15, 5, OP_SUB, 4);

    // backpressure: held output, pending independent instruction
    drive(1, OP_ADD, 1, 2, 6, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_ready", issue_ready, 0);
      tick();
      chk_out("bp_hold", 1, 15, 5, OP_SUB, 4);
    end
    alu_ready = 1'b1;
    #1 chk("bp_release", issue_ready, 1);
    tick();
    chk_out("bp_next", 1, 10, 5, OP_ADD, 6);

    // R0 rules
    drive(0, OP_AND, 0, 0, 0, 1, 0, 'h7FFFF, 1); tick();
    drive(1, OP_AND, 0, 0, 0, 0, 0, 0, 1);
    #1 chk("r0_ready", issue_ready, 1);
    tick();
    chk_out("r0", 1, 0, 0, OP_AND, 0);
    #1 chk("r0_no_busy", issue_ready, 1);

    // same-cycle wb R5 and accept of DEC rd=5: busy stays set
    drive(1, OP_DEC, 5, 0, 5, 1, 5, 9, 1);
    #1 chk("dec_ready", issue_ready, 1);
    tick();
    chk_out("dec", 1, 9, 0, OP_DEC, 5);
    drive(1, OP_ADD, 5, 0, 7, 0, 0, 0, 1);
    for (int i = 0; i < 2; i++) begin
      #1 chk("r5_stall", issue_ready, 0);
      tick();
    end
    drive(1, OP_ADD, 5, 0, 7, 1, 5, 20, 1);
    #1 chk("r5_release", issue_ready, 1);
    tick();
    chk_out("r5", 1, 20, 0, OP_ADD, 7);

    // async reset in the middle of a hold
    drive(1, OP_ADD, 1, 2, 8, 0, 0, 0, 1); tick();
    drive(0, OP_ADD, 0, 0, 0, 0, 0, 0, 0); tick();
    chk("hold_valid", alu_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_ready", issue_ready, 0);
    chk_out("arst", 0, 0, 0, 5'd0, 0);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    drive(1, OP_ADD, 1, 5, 6, 0, 0, 0, 1);
    #1 chk("post_rst_ready", issue_ready, 1);
    tick();
    chk_out("post_rst", 1, 0, 0, OP_ADD, 6);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 9) < 7, OS'($urandom), $urandom_range(0, NR-1),
            $urandom_range(0, NR-1), $urandom_range(0, NR-1),
            $urandom_range(0, 1), $urandom_range(0, NR-1), int'($urandom & 'h7FFFF),
            $urandom_range(0, 3) != 0);
      tick();
    end

    drive(0, OP_ADD, 0, 0, 0, 0, 0, 0, 1);
    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
- Issue/operand-fetch stage directly upstream of arith_logic_unit.
- Holds the architectural register file (NUM_REGS x WORD_SIZE) and a per-register busy scoreboard.
- Accepts decoded instructions, reads two operands with write-back bypass, and presents reg_data_1 / reg_data_2 / ALU_control to the ALU through a one-entry registered valid/ready output stage.
- Write-back of ALU results returns through the wb_* port.

Parameters:
WORD_SIZE, 19, datapath width (matches constants::WORD_SIZE)
OPCODE_SIZE, 5, ALU opcode width (matches constants::OPCODE_SIZE)
NUM_REGS, 16, number of architectural registers
REG_ADDR_W, 4, register index width, equal to clog2(NUM_REGS)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
issue_valid  input  1  decoded instruction present
issue_ready  output  1  stage accepts instruction this cycle
issue_opcode  input  OPCODE_SIZE  ALU operation (opcodes package encoding)
issue_rs1  input  REG_ADDR_W  source register 1
issue_rs2  input  REG_ADDR_W  source register 2
issue_rd  input  REG_ADDR_W  destination register
wb_en  input  1  write-back strobe
wb_addr  input  REG_ADDR_W  write-back register
wb_data  input  WORD_SIZE  write-back value
reg_data_1  output  WORD_SIZE  operand 1 to ALU
reg_data_2  output  WORD_SIZE  operand 2 to ALU
ALU_control  output  OPCODE_SIZE  opcode to ALU
alu_rd  output  REG_ADDR_W  destination tag travelling with the operation
alu_valid  output  1  output stage holds a valid operation
alu_ready  input  1  downstream consumes operation this cycle

Behaviour:
- Reset (async, immediate):
  - All registers = 0 and all busy bits = 0.
  - alu_valid = 0; reg_data_1, reg_data_2, ALU_control and alu_rd = 0.
  - issue_ready goes low while rst is high.
  - Reset asserted mid-operation discards any held operation and any busy state.
- R0:
  - Always reads 0; writes to R0 are ignored.
  - Never marked busy and never causes a hazard.
- Hazard (combinational):
  - A register is a hazard if r != 0, busy[r] = 1, and NOT (wb_en and wb_addr == r).
  - haz = hazard(rs1) or hazard(rs2) or hazard(rd). The rd check prevents WAW.
- issue_ready = !rst and !haz and (!alu_valid or alu_ready).
- Accept: an instruction is accepted when issue_valid and issue_ready on a rising edge. On that edge:
  - reg_data_N <= 0 if rsN == 0; else wb_data if wb_en and wb_addr == rsN (bypass); else regs[rsN].
  - ALU_control <= issue_opcode; alu_rd <= issue_rd; alu_valid <= 1.
  - busy[issue_rd] <= 1 if issue_rd != 0.
- Latency: one cycle from accept to alu_valid. Back-to-back independent instructions sustain one per cycle while alu_ready = 1.
- Hold:
  - While alu_valid and !alu_ready, all ALU-facing outputs remain stable.
  - If alu_ready is high and no new accept occurs, alu_valid <= 0 and the data outputs retain their last values.
- Write-back:
  - When wb_en and wb_addr != 0: regs[wb_addr] <= wb_data and busy[wb_addr] <= 0.
  - Writes to non-busy registers are allowed (external load path).
- Simultaneous wb and accept to the same rd: the set from the accept wins, so busy stays 1. The register value still updates from wb_data.
- Unary ops (INC, DEC, NOT): rs2 is still read and checked, and the decoder drives issue_rs2 = 0.
- No internal counters wrap. The busy vector is exactly NUM_REGS bits, with bit 0 tied to 0.

Test Plan:
- Reset, then wb R1=10 and R2=5. Issue ADD rs1=1 rs2=2 rd=3 with alu_ready=1 -> next cycle alu_valid=1, reg_data_1=10, reg_data_2=5, ALU_control=ADD, alu_rd=3, busy[3]=1.
- RAW stall: with R3 busy, issue SUB rs1=3 rs2=2 rd=4 -> issue_ready=0 for every cycle until wb R3=15. In that same cycle issue_ready=1 and the instruction is accepted with reg_data_1=15 (bypass) and reg_data_2=5.
- Backpressure: hold alu_ready=0 after an accept with a second independent instruction pending -> issue_ready=0 and outputs unchanged for 3 cycles. Raise alu_ready -> second operation appears on the next edge with no gap.
- R0 rules: wb R0=0x7FFFF, then issue AND rs1=0 rs2=0 rd=0 -> reg_data_1=reg_data_2=0, no busy bit set, and a following instruction reading R0 is never stalled.
- Same-cycle wb R5=9 and accept of DEC rd=5 -> regs[5]=9 and busy[5] stays 1. A later issue reading R5 stalls until the next wb to R5.
- Async reset mid-hold: alu_valid=1 and alu_ready=0, then pulse rst between clock edges -> alu_valid=0, all outputs 0 and all busy bits 0 immediately. After release, issue reading R1 sees 0.
